alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter FIFO_DEPTH SHALL default to 4 and set the result buffer depth (power of two, ≥2).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port in_valid  input  1  instruction present.
REQ-006 Port in_ready  output  1  block accepts an instruction this cycle.
REQ-007 Port opcode  input  myopcode_t (3)  operation: RST, MOV, NOT, ADD, AND, XOR, LSH, RSH.
REQ-008 Port data_1  input  8  operand A.
REQ-009 Port data_2  input  8  operand B.
REQ-010 Port out_valid  output  1  result at FIFO head.
REQ-011 Port out_ready  input  1  consumer takes head result.
REQ-012 Port alu_out  output  8  head result.
REQ-013 Port out_opcode  output  myopcode_t  opcode that produced alu_out.
REQ-014 Port txn_count  output  8  accepted-instruction count, wraps 255→0.

Function
REQ-015 An instruction SHALL be accepted on a rising edge where in_valid && in_ready; a result SHALL be popped where out_valid && out_ready.
REQ-016 Results: RST→0x00; MOV→A; NOT→~A; ADD→(A+B) mod 256; AND→A&B; XOR→A^B; LSH→A<<4 (zero fill); RSH→A>>4 (logical).
REQ-017 Pipeline: stage 1 registers the result; the next edge writes it into the FIFO; an instruction accepted at edge k SHALL appear on alu_out/out_valid in the cycle after edge k+1 when the FIFO is empty.
REQ-018 One instruction per cycle SHALL be sustained when out_ready stays high.
REQ-019 in_ready SHALL be (fifo_count + stage1_valid) < FIFO_DEPTH, from registered state only; no combinational path from out_ready or in_valid.
REQ-020 When the FIFO is full, a simultaneous pop and stage-1 write SHALL both occur with no loss; in_ready reflects the freed slot one cycle later.
REQ-021 alu_out/out_opcode SHALL stay stable while out_valid && !out_ready.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 Accepted instructions SHALL never be dropped except by reset.
REQ-024 txn_count SHALL increment by one per accepted instruction.

Reset
REQ-025 While rst is high: in_ready=0, out_valid=0, alu_out=0x00, out_opcode=RST, txn_count=0, stage 1 and FIFO emptied.
REQ-026 Reset mid-operation SHALL discard all in-flight and buffered results; in_ready=1 in the first cycle after rst falls.

Configuration
REQ-027 With ALU_FLAGS_EN defined, outputs zero_flag (alu_out==0) and carry_flag (ADD carry-out; 0 for other opcodes) SHALL be added, buffered alongside each result, and reset to 0.
REQ-028 Without ALU_FLAGS_EN these ports and their storage SHALL be absent; all other behaviour is identical.

Structure
REQ-029 alu_package SHALL hold myopcode_t, the 8-bit data width constant and the default FIFO depth.
REQ-030 The result buffer SHALL be a sub-module alu_result_fifo (synchronous, show-ahead, count output), instantiated once.

Verification
REQ-031 Reset then ADD A=0xF0 B=0x20, out_ready=1 → alu_out=0x10 two edges after acceptance; carry_flag=1 with ALU_FLAGS_EN.
REQ-032 Back-to-back MOV 0x5A, NOT 0x5A, LSH 0x5A, RSH 0x5A, out_ready=1 → 0x5A, 0xA5, 0xA0, 0x05 on consecutive cycles.
REQ-033 out_ready=0, issue 6 XOR ops → exactly 4 accepted, in_ready=0; outputs stable; release out_ready → 4 results in order; in_ready returns.
REQ-034 FIFO full, out_ready=1 and in_valid=1 every cycle → one pop and one accept per cycle, no loss, txn_count correct.
REQ-035 Assert rst with 3 results buffered → out_valid=0 next cycle, txn_count=0, no stale result after rst falls.
REQ-036 Accept 256 instructions → txn_count wraps to 0x00.

Source files
------------

// File: rtl/alu_package.sv
// Shared types and constants for the ALU execution unit.
//   myopcode_t       : 3-bit operation code (RST, MOV, NOT, ADD, AND, XOR, LSH, RSH)
//   DataWidth        : operand / result width
//   FifoDepthDefault : default result buffer depth
//   alu_compute()    : combinational result and ADD carry-out for one instruction
package alu_package;

    localparam int unsigned DataWidth        = 8;
    localparam int unsigned FifoDepthDefault = 4;

    typedef enum logic [2:0] {
        OpRst = 3'd0,
        OpMov = 3'd1,
        OpNot = 3'd2,
        OpAdd = 3'd3,
        OpAnd = 3'd4,
        OpXor = 3'd5,
        OpLsh = 3'd6,
        OpRsh = 3'd7
    } myopcode_t;

    typedef struct packed {
        logic                 carry;
        logic [DataWidth-1:0] data;
    } alu_res_t;

    function automatic alu_res_t alu_compute(myopcode_t op, logic [DataWidth-1:0] a,
                                             logic [DataWidth-1:0] b);
        logic [DataWidth:0] sum;
        alu_res_t           r;
        sum     = {1'b0, a} + {1'b0, b};
        r.carry = 1'b0;
        r.data  = '0;
        unique case (op)
            OpRst: r.data = '0;
            OpMov: r.data = a;
            OpNot: r.data = ~a;
            OpAdd: begin
                r.data  = sum[DataWidth-1:0];
                r.carry = sum[DataWidth];
            end
            OpAnd: r.data = a & b;
            OpXor: r.data = a ^ b;
            OpLsh: r.data = {a[DataWidth-5:0], 4'b0000};
            OpRsh: r.data = {4'b0000, a[DataWidth-1:4]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Synchronous show-ahead result FIFO.
//   clk_i      : rising-edge clock
//   rst_i      : synchronous active-high reset, empties the buffer
//   wr_en_i    : push wr_data_i (ignored when full unless a pop happens the same cycle)
//   wr_data_i  : entry to store
//   rd_en_i    : pop the head entry (ignored when empty)
//   rd_data_o  : head entry, valid whenever valid_o is high
//   valid_o    : buffer holds at least one entry
//   count_o    : number of stored entries
module alu_result_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [Width-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [Width-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_wr, do_rd;
    logic [Width-1:0] mem_q [Depth];

    always_comb begin
        do_rd    = rd_en_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
        do_wr    = wr_en_i && ((count_q != (PtrW+1)'(Depth)) || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed when count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = mem_q[rd_ptr_q];
        valid_o   = (count_q != '0);
        count_o   = count_q;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: one-stage ALU pipeline feeding a result FIFO.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   in_valid   : instruction present       in_ready  : instruction accepted this cycle
//   opcode     : operation                 data_1/2  : operands A / B
//   out_valid  : result at FIFO head       out_ready : consumer takes head result
//   alu_out    : head result               out_opcode: opcode that produced alu_out
//   txn_count  : accepted-instruction count, wraps at 256
// Optional feature macro ALU_FLAGS_EN adds zero_flag / carry_flag outputs, buffered with
// each result.
module alu_exec_unit
    import alu_package::*;
#(
    parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  myopcode_t            opcode,
    input  logic [DataWidth-1:0] data_1,
    input  logic [DataWidth-1:0] data_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] alu_out,
    output myopcode_t            out_opcode,
    output logic [7:0]           txn_count
`ifdef ALU_FLAGS_EN
    ,
    output logic                 zero_flag,
    output logic                 carry_flag
`endif
);

    localparam int unsigned OpW  = $bits(myopcode_t);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef ALU_FLAGS_EN
    // Entry layout: {carry, zero, opcode, data}
    localparam int unsigned EntryW = DataWidth + OpW + 2;
`else
    // Entry layout: {opcode, data}
    localparam int unsigned EntryW = DataWidth + OpW;
`endif

    logic              accept;
    logic              pop;
    alu_res_t          res;
    logic [EntryW-1:0] s1_entry_q, s1_entry_d;
    logic              s1_valid_q, s1_valid_d;
    logic [7:0]        txn_q, txn_d;
    logic [EntryW-1:0] head;
    logic              fifo_valid;
    logic [CntW-1:0]   fifo_count;
    logic [CntW-1:0]   occupancy;

`ifndef ALU_FLAGS_EN
    logic unused_carry;
    assign unused_carry = res.carry;
`endif

    // Occupancy counts results still owed to the consumer, including the one in stage 1,
    // so in_ready depends only on registered state (and reset).
    always_comb begin
        occupancy = fifo_count + {{(CntW-1){1'b0}}, s1_valid_q};
        in_ready  = ~rst && (occupancy < CntW'(FIFO_DEPTH));
        accept    = in_valid && in_ready;
        res       = alu_compute(opcode, data_1, data_2);
`ifdef ALU_FLAGS_EN
        s1_entry_d = {res.carry, (res.data == '0), opcode, res.data};
`else
        s1_entry_d = {opcode, res.data};
`endif
        s1_valid_d = accept;
        txn_d      = accept ? txn_q + 8'd1 : txn_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
            txn_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            txn_q      <= txn_d;
            if (accept) begin
                s1_entry_q <= s1_entry_d;
            end
        end
    end

    // Stage 1 never finds the FIFO full: in_ready reserved its slot at acceptance.
    alu_result_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EntryW)
    ) u_result_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (s1_valid_q),
        .wr_data_i (s1_entry_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    // Outputs are forced to their reset values for the whole time rst is high.
    always_comb begin
        out_valid  = ~rst && fifo_valid;
        pop        = out_valid && out_ready;
        alu_out    = out_valid ? head[DataWidth-1:0] : '0;
        out_opcode = out_valid ? myopcode_t'(head[DataWidth +: OpW]) : OpRst;
        txn_count  = rst ? 8'd0 : txn_q;
`ifdef ALU_FLAGS_EN
        zero_flag  = out_valid && head[DataWidth + OpW];
        carry_flag = out_valid && head[DataWidth + OpW + 1];
`endif
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus a random phase, checked
// against a queue-based reference model of the accepted-but-not-yet-consumed results.
module tb_alu_exec_unit;
    import alu_package::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    myopcode_t  opcode;
    logic [7:0] data_1, data_2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    myopcode_t  out_opcode;
    logic [7:0] txn_count;
`ifdef ALU_FLAGS_EN
    logic       zero_flag, carry_flag;
`endif

    alu_exec_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .data_1     (data_1),
        .data_2     (data_2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .out_opcode (out_opcode),
        .txn_count  (txn_count)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        myopcode_t  op;
        logic       carry;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_txn = 8'd0;
    int         cyc = 0;
    int         n_acc = 0;
    int         n_pop = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] pop_log[$];
    int         pop_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result from the operation definitions, in plain integer arithmetic.
    function automatic exp_t model(myopcode_t op, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int   ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        r = 0;
        e.carry = 1'b0;
        case (op)
            OpRst: r = 0;
            OpMov: r = ia;
            OpNot: r = 255 - ia;
            OpAdd: begin
                r = (ia + ib) % 256;
                e.carry = (ia + ib) > 255;
            end
            OpAnd: r = ia & ib;
            OpXor: r = ia ^ ib;
            OpLsh: r = (ia * 16) % 256;
            OpRsh: r = ia / 16;
            default: r = 0;
        endcase
        e.data = r[7:0];
        e.op = op;
        e.acc = cyc;
        return e;
    endfunction

    // One clock cycle: check outputs mid-cycle, update the model for the coming edge.
    task automatic tick();
        exp_t h;
        logic vis;
        @(negedge clk);
        if (rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_alu_out", alu_out, 0);
            check("rst_out_opcode", out_opcode, OpRst);
            check("rst_txn_count", txn_count, 0);
        end else begin
            check("txn_count", txn_count, exp_txn);
            check("in_ready", in_ready, exp_q.size() < DEPTH);
            vis = (exp_q.size() > 0) && (exp_q[0].acc + 2 <= cyc);
            check("out_valid", out_valid, vis);
            if (out_valid && exp_q.size() > 0) begin
                h = exp_q[0];
                check("alu_out", alu_out, h.data);
                check("out_opcode", out_opcode, h.op);
`ifdef ALU_FLAGS_EN
                check("zero_flag", zero_flag, h.data == 8'd0);
                check("carry_flag", carry_flag, h.carry);
`endif
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(opcode, data_1, data_2));
                exp_txn = exp_txn + 8'd1;
                n_acc++;
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pop_log.push_back(alu_out);
                pop_cyc.push_back(cyc);
                n_pop++;
            end
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_txn = 8'd0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        check("out_valid_after_rst", out_valid, 0);
        check("txn_after_rst", txn_count, 0);
    endtask

    task automatic drive(input myopcode_t op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        opcode = op;
        data_1 = a;
        data_2 = b;
    endtask

    initial begin
        int a0, p0, base;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opcode = OpRst;
        data_1 = 8'd0;
        data_2 = 8'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ADD with carry: result two edges after acceptance.
        out_ready = 1'b1;
        drive(OpAdd, 8'hF0, 8'h20);
        tick();
        in_valid = 1'b0;
        check("add_not_yet", out_valid, 0);
        tick();
        check("add_valid", out_valid, 1);
        check("add_result", alu_out, 8'h10);
`ifdef ALU_FLAGS_EN
        check("add_carry", carry_flag, 1);
`endif
        tick();

        // Back-to-back MOV/NOT/LSH/RSH.
        pop_log.delete();
        pop_cyc.delete();
        drive(OpMov, 8'h5A, 8'h00); tick();
        drive(OpNot, 8'h5A, 8'h00); tick();
        drive(OpLsh, 8'h5A, 8'h00); tick();
        drive(OpRsh, 8'h5A, 8'h00); tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("b2b_count", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            check("b2b_0", pop_log[0], 8'h5A);
            check("b2b_1", pop_log[1], 8'hA5);
            check("b2b_2", pop_log[2], 8'hA0);
            check("b2b_3", pop_log[3], 8'h05);
            check("b2b_consecutive", pop_cyc[3] - pop_cyc[0], 3);
        end

        // Stall: only DEPTH instructions accepted, then drain in order.
        out_ready = 1'b0;
        a0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive(OpXor, 8'($urandom), 8'($urandom));
            tick();
        end
        in_valid = 1'b0;
        check("stall_accepts", n_acc - a0, 4);
        check("stall_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        p0 = n_pop;
        repeat (6) tick();
        check("stall_drained", n_pop - p0, 4);
        check("stall_in_ready_back", in_ready, 1);

        // Full FIFO with continuous traffic: one pop and one accept per cycle.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(myopcode_t'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom));
            tick();
        end
        out_ready = 1'b1;
        a0 = n_acc;
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            drive(myopcode_t'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom));
            tick();
        end
        in_valid = 1'b0;
        check("full_pops", n_pop - p0, 20);
        check("full_accepts", n_acc - a0, 19);
        repeat (6) tick();

        // Reset with three buffered results.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OpMov, 8'(8'h30 + i), 8'h00);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_txn", txn_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        p0 = n_pop;
        repeat (5) tick();
        check("no_stale", n_pop - p0, 0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            opcode = myopcode_t'(3'($urandom_range(0, 7)));
            data_1 = 8'($urandom);
            data_2 = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("random_drained", exp_q.size(), 0);

        // 256 accepts from reset wraps the counter.
        do_reset();
        out_ready = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 600 && (n_acc - a0) < 256; i++) begin
            drive(myopcode_t'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom));
            tick();
        end
        in_valid = 1'b0;
        check("wrap_accepts", n_acc - a0, 256);
        check("wrap_txn", txn_count, 8'h00);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
